// File: rtl/tnn_feature_frontend.sv
// tnn_feature_frontend
//   Collects five raw feature beats per sample frame and quantizes each one to
//   a 3-bit level. The five levels are presented to an external combinational
//   classifier core. After CLS_LAT cycles the core's decision is captured and
//   offered on a valid/ready result port. Malformed frames are dropped and
//   flagged with a one-cycle err_pulse.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last
//                            raw feature stream (one beat per transfer)
//   input_a..input_e         quantized features driven to the classifier
//   cgp_out                  classifier decision (combinational from input_a..e)
//   m_valid/m_ready/m_class  captured decision, valid/ready handshake
//   frame_cnt                completed-result counter, wraps at 16 bits
//   err_pulse                one-cycle pulse per dropped malformed frame
module tnn_feature_frontend #(
    parameter int FEAT_W  = 8,
    parameter int CLS_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [FEAT_W-1:0] s_data,
    input  logic              s_last,
    output logic [2:0]        input_a,
    output logic [2:0]        input_b,
    output logic [2:0]        input_c,
    output logic [2:0]        input_d,
    output logic [2:0]        input_e,
    input  logic              cgp_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_class,
    output logic [15:0]       frame_cnt,
    output logic              err_pulse
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EVAL    = 2'd1,
        HOLD    = 2'd2,
        RESYNC  = 2'd3
    } state_t;

    // Rounding offset: half of one quantization step.
    localparam logic [FEAT_W:0] RND = {{FEAT_W{1'b0}}, 1'b1} << (FEAT_W - 4);

    state_t          state, state_nxt;
    logic [2:0]      idx;
    logic [3:0]      lat_cnt;
    logic [3:0][2:0] shadow;

    logic [FEAT_W:0] q_sum;
    logic [FEAT_W:0] q_shift;
    logic [2:0]      q;
    logic            xfer;
    logic            eval_done;
    logic            load_feat;
    logic            err_nxt;

    // Quantizer: sum kept one bit wider so the rounding add cannot overflow;
    // anything that lands above level 7 saturates.
    assign q_sum   = {1'b0, s_data} + RND;
    assign q_shift = q_sum >> (FEAT_W - 3);
    assign q       = (|q_shift[FEAT_W:3]) ? 3'd7 : q_shift[2:0];

    assign s_ready   = rst_n && ((state == COLLECT) || (state == RESYNC));
    assign m_valid   = (state == HOLD);
    assign xfer      = s_valid && s_ready;
    assign eval_done = (state == EVAL) && (lat_cnt == 4'(CLS_LAT - 1));

    always_comb begin
        state_nxt = state;
        load_feat = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            COLLECT: begin
                if (xfer) begin
                    if (idx == 3'd4) begin
                        if (s_last) begin
                            load_feat = 1'b1;
                            state_nxt = EVAL;
                        end else begin
                            // Too many beats: drop and skip to the frame end.
                            err_nxt   = 1'b1;
                            state_nxt = RESYNC;
                        end
                    end else if (s_last) begin
                        err_nxt = 1'b1;
                    end
                end
            end
            EVAL: begin
                if (eval_done) state_nxt = HOLD;
            end
            HOLD: begin
                if (m_ready) state_nxt = COLLECT;
            end
            RESYNC: begin
                if (xfer && s_last) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= COLLECT;
            idx       <= 3'd0;
            lat_cnt   <= 4'd0;
            shadow    <= '0;
            input_a   <= 3'd0;
            input_b   <= 3'd0;
            input_c   <= 3'd0;
            input_d   <= 3'd0;
            input_e   <= 3'd0;
            m_class   <= 1'b0;
            frame_cnt <= 16'd0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            err_pulse <= err_nxt;

            if ((state == COLLECT) && xfer) begin
                // Index restarts on any frame end, good or bad.
                idx <= ((idx == 3'd4) || s_last) ? 3'd0 : idx + 3'd1;
                if (idx != 3'd4) shadow[idx[1:0]] <= q;
            end

            // Fifth level bypasses the shadow so all five load on one edge.
            if (load_feat) begin
                input_a <= shadow[0];
                input_b <= shadow[1];
                input_c <= shadow[2];
                input_d <= shadow[3];
                input_e <= q;
            end

            lat_cnt <= (state == EVAL) ? lat_cnt + 4'd1 : 4'd0;

            if (eval_done) m_class <= cgp_out;

            if ((state == HOLD) && m_ready) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_tnn_feature_frontend.sv
module tb_tnn_feature_frontend;

    localparam int FEAT_W  = 8;
    localparam int CLS_LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [FEAT_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic [2:0]        input_a, input_b, input_c, input_d, input_e;
    logic              cgp_out;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic              m_class;
    logic [15:0]       frame_cnt;
    logic              err_pulse;

    tnn_feature_frontend #(.FEAT_W(FEAT_W), .CLS_LAT(CLS_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .input_a(input_a), .input_b(input_b), .input_c(input_c),
        .input_d(input_d), .input_e(input_e),
        .cgp_out(cgp_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
        .frame_cnt(frame_cnt), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in classifier core: an arbitrary combinational function of the levels.
    function automatic logic cls_fn(input logic [4:0][2:0] v);
        int s;
        s = int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]) + int'(v[4]);
        return ((s % 3) == 0) ^ (v[0] > v[4]);
    endfunction

    assign cgp_out = cls_fn({input_e, input_d, input_c, input_b, input_a});

    // Reference quantizer written straight from the rounding/saturation rule.
    function automatic logic [2:0] quant(input int d);
        int qv;
        qv = (d + (1 << (FEAT_W - 4))) / (1 << (FEAT_W - 3));
        if (qv > 7) qv = 7;
        return 3'(qv);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [4:0][2:0] q;
        logic            cls;
        int              vcyc;
    } exp_t;

    exp_t        frq[$];
    int          errq[$];
    logic [15:0] model_cnt = 16'd0;
    logic        prev_v = 1'b0;
    logic        hold_cls = 1'b0;
    int          mr_mode = 0;

    // Consumer ready: 0 = always ready, 1 = random, 2 = stalled.
    always @(posedge clk) begin
        #1;
        case (mr_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            frq.delete();
            errq.delete();
            model_cnt = 16'd0;
            prev_v    = 1'b0;
            chk("rst_s_ready", s_ready, 0);
        end else begin
            chk("frame_cnt", frame_cnt, model_cnt);
            if (err_pulse) begin
                if (errq.size() == 0) chk("err_unexpected", 1, 0);
                else chk("err_cycle", cyc, errq.pop_front());
            end
            if (m_valid && !prev_v) begin
                if (frq.size() == 0) begin
                    chk("valid_unexpected", 1, 0);
                end else begin
                    e = frq.pop_front();
                    chk("latency", cyc, e.vcyc);
                    chk("class", m_class, e.cls);
                    chk("features", {input_e, input_d, input_c, input_b, input_a}, e.q);
                end
                hold_cls = m_class;
            end
            if (m_valid) begin
                chk("class_stable", m_class, hold_cls);
                chk("hold_s_ready", s_ready, 0);
                if (m_ready) model_cnt = model_cnt + 16'd1;
            end
            prev_v = m_valid;
        end
    end

    logic [FEAT_W-1:0] fr_data [8];

    task automatic send_beat(input logic [FEAT_W-1:0] d, input logic last, output int e);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_ready && n < 300);
        if (!s_ready) chk("s_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        e = cyc;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit gaps);
        int e;
        exp_t x;
        for (int i = 0; i < n; i++) begin
            send_beat(fr_data[i], (i == n - 1), e);
            if (n == 5 && i == 4) begin
                for (int k = 0; k < 5; k++) x.q[k] = quant(int'(fr_data[k]));
                x.cls  = cls_fn(x.q);
                x.vcyc = e + CLS_LAT;
                frq.push_back(x);
            end
            if (n < 5 && i == n - 1) errq.push_back(e);
            if (n > 5 && i == 4) errq.push_back(e);
            if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
            if (gaps) #1;
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < 8; i++) fr_data[i] = FEAT_W'($urandom);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, m_valid, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((frq.size() != 0 || m_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", (frq.size() == 0 && !m_valid) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_features", {input_e, input_d, input_c, input_b, input_a}, 0);
        chk("rst_m_class", m_class, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_pulse", err_pulse, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready, 1);

        // Known quantization points.
        fr_data[0] = 8'h00; fr_data[1] = 8'h10; fr_data[2] = 8'h2F;
        fr_data[3] = 8'h30; fr_data[4] = 8'hF0;
        @(posedge clk); #1;
        send_frame(5, 0);
        wait_valid("quant_valid");
        chk("quant_a", input_a, 0);
        chk("quant_b", input_b, 1);
        chk("quant_c", input_c, 1);
        chk("quant_d", input_d, 2);
        chk("quant_e", input_e, 7);
        @(negedge clk);
        chk("single_cycle_valid", m_valid, 0);
        chk("cnt_after_first", frame_cnt, 1);
        drain();

        // Short frame, then a normal one.
        @(posedge clk); #1;
        rand_data(); send_frame(3, 0);
        rand_data(); send_frame(5, 0);
        drain();

        // Long frame absorbed in resync, then a normal one.
        @(posedge clk); #1;
        rand_data(); send_frame(7, 0);
        rand_data(); send_frame(5, 0);
        drain();

        // Backpressure.
        mr_mode = 2;
        @(posedge clk); #1;
        rand_data(); send_frame(5, 0);
        wait_valid("bp_valid");
        repeat (20) @(negedge clk);
        chk("bp_still_valid", m_valid, 1);
        chk("bp_cnt_held", frame_cnt, model_cnt);
        mr_mode = 0;
        drain();

        // Reset while holding a result.
        mr_mode = 2;
        @(posedge clk); #1;
        rand_data(); send_frame(5, 0);
        wait_valid("hold_valid");
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_m_valid", m_valid, 0);
        chk("rst_hold_cnt", frame_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mr_mode = 0;
        @(negedge clk);
        chk("rst_hold_s_ready", s_ready, 1);

        // Reset in the middle of a frame, then a clean frame.
        @(posedge clk); #1;
        send_beat(8'hFF, 1'b0, e);
        send_beat(8'hFF, 1'b0, e);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rand_data(); send_frame(5, 0);
        drain();

        // Random traffic with random gaps and backpressure.
        mr_mode = 1;
        @(posedge clk); #1;
        for (int f = 0; f < 200; f++) begin
            int n;
            n = ($urandom_range(0, 9) < 6) ? 5 : int'($urandom_range(1, 8));
            rand_data();
            send_frame(n, 1);
        end
        mr_mode = 0;
        drain();

        // Counter wrap: preload near the top while idle.
        @(posedge clk); #1;
        force dut.frame_cnt = 16'hFFFE;
        model_cnt = 16'hFFFE;
        @(posedge clk); #1;
        release dut.frame_cnt;
        rand_data(); send_frame(5, 0);
        rand_data(); send_frame(5, 0);
        drain();
        chk("wrap_cnt", frame_cnt, 0);

        chk("frames_left", frq.size(), 0);
        chk("errs_left", errq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
